dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//   Load/store unit that issues CPU memory requests to the word-addressed data memory.
//   That memory offers only full-word writes and a combinational read, so the LSU handles
//   byte/halfword stores (SB/SH) as read-modify-write. It does load lane extraction and
//   sign/zero extension (LB/LBU/LH/LHU/LW). It flags misaligned, illegal-funct3 and
//   out-of-range accesses. It sits between the execute stage and the data memory.
// PARAMETERS
//   MEM_WORDS  4096  words in the attached data memory; valid byte addresses are 0..MEM_WORDS*4-1
// PORTS
//   clk             in   1   clock; every flop is rising-edge
//   rst_n           in   1   reset, asynchronous, active-low
//   req_valid       in   1   request present
//   req_ready       out  1   LSU can accept; a request is accepted when req_valid && req_ready
//   req_write       in   1   1 = store, 0 = load
//   req_funct3      in   3   RV32I funct3 (load: 0 LB,1 LH,2 LW,4 LBU,5 LHU; store: 0 SB,1 SH,2 SW)
//   req_addr        in   32  byte address
//   req_wdata       in   32  store data; low byte/halfword is used for SB/SH
//   resp_valid      out  1   one-cycle pulse marking request completion; no backpressure
//   resp_rdata      out  32  extended load data; 0 for stores and for errors
//   resp_error      out  1   valid with resp_valid: misaligned, illegal funct3, or out of range
//   busy            out  1   request in flight (state != IDLE); pipeline stalls on it
//   mem_addr        out  32  word-aligned address {addr[31:2],2'b00}
//   mem_write_data  out  32  full word written to memory
//   mem_read        out  1   read strobe; mem_read_data is valid in the same cycle
//   mem_write       out  1   write strobe; memory writes at the next rising edge
//   mem_read_data   in   32  combinational read data from memory
// BEHAVIOUR
//   FSM states IDLE, RD, WR, RESP. On accept, register write, funct3, addr and wdata.
//   - IDLE: req_ready=1. On accept:
//       error -> RESP; LW/LB/LBU/LH/LHU -> RD; SW -> WR; SB/SH -> RD.
//   - RD: mem_read=1. Capture mem_read_data into the data register.
//       Load -> RESP. SB/SH -> WR.
//   - WR: mem_write=1.
//       SW: mem_write_data = wdata.
//       SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
//       SH: captured word with halfword lane addr[1] replaced by wdata[15:0].
//       Next state is RESP.
//   - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 here.
//   Error rules:
//     - LH/LHU/SH with addr[0]=1 is misaligned.
//     - LW/SW with addr[1:0]!=0 is misaligned.
//     - funct3 3/6/7 on loads, or >2 on stores, is illegal.
//     - addr >= MEM_WORDS*4 is out of range.
//     An errored request never raises mem_read or mem_write.
//   Latency counts from the accept edge T:
//     - error: resp at T+1
//     - LW/LB/LH/LBU/LHU/SW: resp at T+2
//     - SB/SH: resp at T+3
//   Load extraction:
//     - LB/LBU take the byte at lane addr[1:0].
//     - LH/LHU take the halfword at lane addr[1].
//     - LB/LH sign-extend; LBU/LHU zero-extend.
//   Outside RD/WR, mem_addr=0 and mem_write_data=0. mem_addr is held constant across RD->WR.
//   resp_rdata and resp_error are 0 whenever resp_valid=0.
//   req_valid while busy is ignored; the LSU never accepts a second request mid-op.
//   Reset values: state=IDLE, req_ready=1, every other output 0.
//   Reset mid-op: rst_n low forces IDLE immediately. mem_read/mem_write drop asynchronously.
//   The in-flight request is discarded with no resp_valid. A store caught in RD never writes.
// TESTING
//   1 reset; SW addr 0x10 data 0xDEADBEEF -> T+1 mem_write=1, mem_addr=0x10,
//     mem_write_data=0xDEADBEEF; T+2 resp_valid=1, resp_error=0
//   2 word 0x10=0xDEADBEEF:
//     - LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE
//     - LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF
//     - each with resp_valid at T+2
//   3 SB 0x11 data 0x55 on word 0xDEADBEEF -> T+1 mem_read=1; T+2 mem_write=1,
//     mem_write_data=0xDEAD55EF; T+3 resp_valid
//   4 LW 0x06, SH 0x11, LB funct3=3, SW 0x4000 (MEM_WORDS=4096) -> resp_valid=1,
//     resp_error=1 at T+1; mem_read=mem_write=0 throughout
//   5 req_valid held high across SB -> req_ready=0 for T+1..T+3; next accept only in IDLE at T+4
//   6 rst_n pulsed low during WR of an SB -> mem_write drops immediately; word unchanged
//     on readback; no resp_valid; req_ready=1 after release

Source files
------------

// File: rtl/dmem_lsu_if.sv
// CPU request/response and data-memory bus for the load/store unit.
// The slave modport is the LSU side; the master modport is the execute/memory side.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_addr, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy,
           mem_addr, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit for a word-only data memory: sub-word stores become read-modify-write,
// loads get lane extraction and sign/zero extension, bad requests answer with an error.
module dmem_lsu #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input logic       clk,
  input logic       rst_n,
  dmem_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        req_err;
  logic        illegal;
  logic        misalign;
  logic [4:0]  shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = bus.req_valid && (state_q == IDLE);

  // funct3[1:0] encodes access size for both loads and stores once funct3 is legal
  always_comb begin
    illegal  = bus.req_write ? (bus.req_funct3 > 3'd2)
                             : (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6);
    misalign = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
    req_err  = illegal || misalign || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      err_q    <= err_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    err_d    = err_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    case (state_q)
      IDLE: if (accept) begin
        write_d  = bus.req_write;
        err_d    = req_err;
        funct3_d = bus.req_funct3;
        addr_d   = bus.req_addr;
        wdata_d  = bus.req_wdata;
        if (req_err)                                     state_d = RESP;
        else if (bus.req_write && bus.req_funct3 == 3'd2) state_d = WR;
        else                                             state_d = RD;
      end
      RD: begin
        data_d  = bus.mem_read_data;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Lane selection shared by load extraction and sub-word store merge
  always_comb begin
    shift  = {addr_q[1:0], 3'b000};
    lane_b = 8'(data_q >> shift);
    lane_h = addr_q[1] ? data_q[31:16] : data_q[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_ext = {24'd0, lane_b};
      3'd5:    load_ext = {16'd0, lane_h};
      default: load_ext = data_q;
    endcase
    case (funct3_q)
      3'd0:    merged = (data_q & ~(32'h0000_00FF << shift)) | ({24'd0, wdata_q[7:0]} << shift);
      3'd1:    merged = addr_q[1] ? {wdata_q[15:0], data_q[15:0]} : {data_q[31:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.busy           = (state_q != IDLE);
    bus.mem_read       = (state_q == RD);
    bus.mem_write      = (state_q == WR);
    bus.mem_addr       = 32'd0;
    bus.mem_write_data = 32'd0;
    bus.resp_valid     = (state_q == RESP);
    bus.resp_error     = 1'b0;
    bus.resp_rdata     = 32'd0;
    if (state_q == RD || state_q == WR) bus.mem_addr = {addr_q[31:2], 2'b00};
    if (state_q == WR)                  bus.mem_write_data = merged;
    if (state_q == RESP) begin
      bus.resp_error = err_q;
      if (!err_q && !write_q) bus.resp_rdata = load_ext;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-addressed memory model and hand-computed expectations.
module tb_dmem_lsu;
  localparam int unsigned MEM_WORDS = 4096;
  localparam int AW = $clog2(MEM_WORDS);

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  logic [31:0] mem [MEM_WORDS];

  dmem_lsu_if bus ();

  dmem_lsu #(.MEM_WORDS(MEM_WORDS)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always_comb bus.mem_read_data = mem[bus.mem_addr[AW+1:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[AW+1:2]] <= bus.mem_write_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; hold keeps req_valid high afterwards
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic hold);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    step();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    step();
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.busy, bus.mem_read, bus.mem_write} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100000",
               {bus.req_ready, bus.resp_valid, bus.resp_error, bus.busy, bus.mem_read, bus.mem_write});
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_addr, bus.mem_write_data} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0", bus.resp_rdata, bus.mem_addr, bus.mem_write_data);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sw();
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if ({bus.mem_write, bus.mem_read, bus.resp_valid} !== 3'b100) begin
      errors++; $display("FAIL sw_t1_strobes got %b exp 100", {bus.mem_write, bus.mem_read, bus.resp_valid});
    end
    checks++;
    if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL sw_addr got %h exp 00000010", bus.mem_addr); end
    checks++;
    if (bus.mem_write_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_wdata got %h exp deadbeef", bus.mem_write_data);
    end
    step();
    checks++;
    if ({bus.resp_valid, bus.resp_error, bus.mem_write} !== 3'b100 || bus.resp_rdata !== 32'd0) begin
      errors++; $display("FAIL sw_resp got v%b e%b w%b d%h exp v1 e0 w0 d0",
                         bus.resp_valid, bus.resp_error, bus.mem_write, bus.resp_rdata);
    end
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem got %h exp deadbeef", mem[4]); end
    step();
    checks++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      errors++; $display("FAIL sw_idle got %b exp 10", {bus.req_ready, bus.resp_valid});
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd4};
    logic [31:0] adrs [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
    logic [31:0] exps [6] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF,
                              32'hDEAD_BEEF, 32'h0000_00BE};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'hFFFF_FFFF, 1'b0);
      checks++;
      if ({bus.mem_read, bus.mem_write, bus.resp_valid} !== 3'b100 || bus.mem_addr !== 32'h10) begin
        errors++; $display("FAIL load%0d_t1 got r%b w%b v%b a%h exp r1 w0 v0 a00000010", i,
                           bus.mem_read, bus.mem_write, bus.resp_valid, bus.mem_addr);
      end
      step();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_rdata !== exps[i]) begin
        errors++; $display("FAIL load%0d_resp got v%b e%b d%h exp v1 e0 d%h", i,
                           bus.resp_valid, bus.resp_error, bus.resp_rdata, exps[i]);
      end
      step();
    end
    // Last valid word is in range
    issue(1'b0, 3'd2, 32'h3FFC, 32'd0, 1'b0);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h3FFC) begin
      errors++; $display("FAIL lw_top_t1 got r%b a%h exp r1 a00003ffc", bus.mem_read, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0) begin
      errors++; $display("FAIL lw_top_resp got v%b e%b exp v1 e0", bus.resp_valid, bus.resp_error);
    end
    step();
  endtask

  task automatic test_subword_store();
    issue(1'b1, 3'd0, 32'h11, 32'hAABB_CC55, 1'b0);
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b10 || bus.mem_addr !== 32'h10) begin
      errors++; $display("FAIL sb_t1 got r%b w%b a%h exp r1 w0 a00000010", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    step();
    checks++;
    if ({bus.mem_read, bus.mem_write} !== 2'b01 || bus.mem_addr !== 32'h10 || bus.mem_write_data !== 32'hDEAD_55EF) begin
      errors++; $display("FAIL sb_t2 got r%b w%b a%h d%h exp r0 w1 a00000010 ddead55ef",
                         bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_write_data);
    end
    step();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_error !== 1'b0 || bus.resp_rdata !== 32'd0) begin
      errors++; $display("FAIL sb_resp got v%b e%b d%h exp v1 e0 d0", bus.resp_valid, bus.resp_error, bus.resp_rdata);
    end
    step();
    issue(1'b1, 3'd1, 32'h12, 32'hFFFF_1234, 1'b0);
    step();
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_write_data !== 32'h1234_55EF) begin
      errors++; $display("FAIL sh_t2 got w%b d%h exp w1 d123455ef", bus.mem_write, bus.mem_write_data);
    end
    step();
    checks++;
    if (bus.resp_valid !== 1'b1 || mem[4] !== 32'h1234_55EF) begin
      errors++; $display("FAIL sh_resp got v%b mem %h exp v1 mem 123455ef", bus.resp_valid, mem[4]);
    end
    step();
  endtask

  task automatic test_errors();
    logic        ws   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
    logic [31:0] adrs [4] = '{32'h06, 32'h11, 32'h10, 32'h4000};
    for (int i = 0; i < 4; i++) begin
      issue(ws[i], f3s[i], adrs[i], 32'h1234_5678, 1'b0);
      checks++;
      if ({bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write} !== 4'b1100 || bus.resp_rdata !== 32'd0) begin
        errors++; $display("FAIL err%0d_resp got v%b e%b r%b w%b d%h exp v1 e1 r0 w0 d0", i,
                           bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write, bus.resp_rdata);
      end
      step();
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write} !== 5'b10000) begin
        errors++; $display("FAIL err%0d_after got %b exp 10000", i,
                           {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write});
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 3'd2, 32'h20, 32'h1122_3344, 1'b0);
    step(); step();
    issue(1'b1, 3'd0, 32'h21, 32'h0000_0099, 1'b1);
    // A different request waits on the bus; it must not be taken mid-op
    bus.req_write = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h20;
    checks++;
    if ({bus.req_ready, bus.mem_read} !== 2'b01) begin
      errors++; $display("FAIL b2b_t1 got rdy%b r%b exp rdy0 r1", bus.req_ready, bus.mem_read);
    end
    step();
    checks++;
    if ({bus.req_ready, bus.mem_write} !== 2'b01 || bus.mem_write_data !== 32'h1122_9944) begin
      errors++; $display("FAIL b2b_t2 got rdy%b w%b d%h exp rdy0 w1 d11229944",
                         bus.req_ready, bus.mem_write, bus.mem_write_data);
    end
    step();
    checks++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b01) begin
      errors++; $display("FAIL b2b_t3 got rdy%b v%b exp rdy0 v1", bus.req_ready, bus.resp_valid);
    end
    step();
    checks++;
    if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
      errors++; $display("FAIL b2b_t4 got %b exp 100", {bus.req_ready, bus.busy, bus.resp_valid});
    end
    step();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.req_ready, bus.busy, bus.mem_read} !== 3'b011) begin
      errors++; $display("FAIL b2b_accept got %b exp 011", {bus.req_ready, bus.busy, bus.mem_read});
    end
    step();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1122_9944) begin
      errors++; $display("FAIL b2b_lw got v%b d%h exp v1 d11229944", bus.resp_valid, bus.resp_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int resp_seen = 0;
    issue(1'b1, 3'd2, 32'h30, 32'hCAFE_F00D, 1'b0);
    step(); step();
    issue(1'b1, 3'd0, 32'h30, 32'h0000_0077, 1'b0);
    step();
    checks++;
    if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rst_mid_wr got w%b exp w1", bus.mem_write); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_write, bus.busy, bus.req_ready} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_drop got %b exp 001", {bus.mem_write, bus.busy, bus.req_ready});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.resp_valid) resp_seen++;
      step();
    end
    checks++;
    if (resp_seen != 0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_resp got resp %0d rdy%b exp resp 0 rdy1", resp_seen, bus.req_ready);
    end
    issue(1'b0, 3'd2, 32'h30, 32'd0, 1'b0);
    step();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_mid_readback got v%b d%h exp v1 dcafef00d", bus.resp_valid, bus.resp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
